// File: rtl/scu_ctrl_pkg.sv
// SCU control-unit shared definitions: opcode/aluOp/redirect encodings and the per-stage control bundle.
// Pure declarations; no latency, no flow control.
package scu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_NEG = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_MEM = 4'd4;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_EX   = 2'b01;
  localparam logic [1:0] SRC_MEM  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       imm_gen;
    logic       load_store;
    logic       jump;
    logic       jump_mem;
    logic       branch_z;
    logic       branch_n;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/scu_decoder.sv
// Combinational opcode -> control bundle decode with undefined-opcode flag; zero latency.
// No flow control; undefined opcodes (including any nonzero bits above the low nibble) decode as nop.
module scu_decoder
  import scu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  logic hi_set;
  assign hi_set = (opcode >> 4) != '0;

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (hi_set) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_NOP: ;
        OP_SVPC: begin
          ctrl.reg_write = 1'b1; ctrl.pc_to_reg = 1'b1; ctrl.alu_src = 1'b1;
          ctrl.alu_op = ALU_ADD;
        end
        OP_LD: begin
          ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.mem_read = 1'b1;
          ctrl.load_store = 1'b1; ctrl.alu_op = ALU_MEM;
        end
        OP_ST: begin
          ctrl.mem_write = 1'b1; ctrl.load_store = 1'b1; ctrl.alu_op = ALU_MEM;
        end
        OP_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
        OP_INC: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.imm_gen = 1'b1;
          ctrl.alu_op = ALU_ADD;
        end
        OP_NEG: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_NEG; end
        OP_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
        OP_J:   begin ctrl.jump = 1'b1; ctrl.alu_op = ALU_NOP; end
        OP_JM: begin
          ctrl.jump = 1'b1; ctrl.jump_mem = 1'b1; ctrl.mem_read = 1'b1;
          ctrl.load_store = 1'b1; ctrl.alu_op = ALU_MEM;
        end
        OP_BRZ: begin ctrl.branch_z = 1'b1; ctrl.load_store = 1'b1; ctrl.alu_op = ALU_MEM; end
        OP_BRN: begin ctrl.branch_n = 1'b1; ctrl.load_store = 1'b1; ctrl.alu_op = ALU_MEM; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// SCU control: ID decode feeding ID/EX, EX/MEM, MEM/WB control registers (EX +1, MEM +2, WB +3 cycles).
// hold freezes everything; load-use stalls PC/IF-ID; EX/MEM redirects flush IF/ID and bubble younger stages.
module pipelined_control_unit
  import scu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_flag_z,
  input  logic                  ex_flag_n,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  pc_redirect,
  output logic [1:0]            redirect_src,
  output logic [ALUOP_W-1:0]    ex_aluOp,
  output logic                  ex_aluSrc,
  output logic                  ex_immGen,
  output logic                  ex_loadStore,
  output logic                  mem_memRead,
  output logic                  mem_memWrite,
  output logic                  wb_regWrite,
  output logic                  wb_memtoReg,
  output logic                  wb_PCtoReg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal_op
);

  ctrl_t                 dec_ctrl, id_ctrl;
  logic                  dec_illegal;
  logic [REG_ADDR_W-1:0] id_rd_eff;

  ctrl_t                 ex_c, mem_c, wb_c;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd_q;
  logic                  illegal_q;

  logic                  mem_redirect, ex_taken, load_use;

  scu_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign id_ctrl   = id_valid ? dec_ctrl : CTRL_NOP;
  assign id_rd_eff = id_valid ? id_rd : '0;

  assign mem_redirect = mem_c.jump_mem;
  assign ex_taken     = (ex_c.jump & ~ex_c.jump_mem) | (ex_c.branch_z & ex_flag_z) |
                        (ex_c.branch_n & ex_flag_n);
  // jm also reads memory, but its data goes to the PC, not a register, so it never causes load-use
  assign load_use     = id_valid & ex_c.mem_read & ~ex_c.jump_mem &
                        ((ex_rd == id_rs) | (ex_rd == id_rt));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    pc_redirect  = 1'b0;
    redirect_src = SRC_NONE;
    if (hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (mem_redirect) begin
      ifid_flush   = 1'b1;
      pc_redirect  = 1'b1;
      redirect_src = SRC_MEM;
    end else if (ex_taken) begin
      ifid_flush   = 1'b1;
      pc_redirect  = 1'b1;
      redirect_src = SRC_EX;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_c      <= CTRL_NOP;
      mem_c     <= CTRL_NOP;
      wb_c      <= CTRL_NOP;
      ex_rd     <= '0;
      mem_rd    <= '0;
      wb_rd_q   <= '0;
      illegal_q <= 1'b0;
    end else if (!hold) begin
      wb_c    <= mem_c;
      wb_rd_q <= mem_rd;
      if (mem_redirect) begin
        mem_c  <= CTRL_NOP;
        mem_rd <= '0;
      end else begin
        mem_c  <= ex_c;
        mem_rd <= ex_rd;
      end
      if (mem_redirect || ex_taken || load_use) begin
        ex_c  <= CTRL_NOP;
        ex_rd <= '0;
      end else begin
        ex_c  <= id_ctrl;
        ex_rd <= id_rd_eff;
      end
      if (id_valid && dec_illegal) illegal_q <= 1'b1;
    end
  end

  assign ex_aluOp     = ALUOP_W'(ex_c.alu_op);
  assign ex_aluSrc    = ex_c.alu_src;
  assign ex_immGen    = ex_c.imm_gen;
  assign ex_loadStore = ex_c.load_store;
  assign mem_memRead  = mem_c.mem_read;
  assign mem_memWrite = mem_c.mem_write;
  assign wb_regWrite  = wb_c.reg_write;
  assign wb_memtoReg  = wb_c.mem_to_reg;
  assign wb_PCtoReg   = wb_c.pc_to_reg;
  assign wb_rd        = wb_rd_q;
  assign illegal_op   = illegal_q;

  logic unused_wb_bits;
  assign unused_wb_bits = ^wb_c;

endmodule
